mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Desc    : Single-outstanding RV32 load/store word memory with a fixed,
//           parameterised request-to-response latency.
// Rev     : 1.0
// ============================================================================
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          wen_q, err_q;
    logic [2:0]    ctrl_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          w_accept, w_commit;
    logic [31:0]   w_addr, w_wdata, w_word, w_shift, w_load, w_wbus;
    logic          w_wen, w_err, w_bad_ctrl, w_bad_store, w_misalign, w_oob;
    logic [2:0]    w_ctrl;
    logic [1:0]    w_lane;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;

    assign req_ready = (state_q == IDLE) && !RST;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

    // With LATENCY=1 the commit edge is the accept edge, so the live request is used.
    assign w_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign w_wen   = (state_q == IDLE) ? req_wen   : wen_q;
    assign w_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign w_ctrl  = (state_q == IDLE) ? req_ctrl  : ctrl_q;
    assign w_lane  = w_addr[1:0];
    assign w_idx   = w_addr[AW+1:2];

    assign w_bad_ctrl  = (w_ctrl == 3'b011) || (w_ctrl[2:1] == 2'b11);
    assign w_bad_store = w_wen && w_ctrl[2];
    assign w_misalign  = ((w_ctrl[1:0] == 2'b01) && w_addr[0]) ||
                         ((w_ctrl[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_oob       = {1'b0, w_addr[31:2]} >= 31'(DEPTH_WORDS);
    assign w_err       = w_bad_ctrl || w_bad_store || w_misalign || w_oob;

    assign w_word  = mem_q[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = 32'd0;
        case (w_ctrl)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = w_shift;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
        if (w_wen || w_err) begin
            w_load = 32'd0;
        end
    end

    always_comb begin
        w_be   = 4'b0000;
        w_wbus = w_wdata;
        case (w_ctrl[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wbus = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << w_lane;
                w_wbus = {2{w_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 32'd1) begin
                        w_commit = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    w_commit = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wen_q   <= 1'b0;
            wdata_q <= 32'd0;
            ctrl_q  <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                addr_q  <= req_addr;
                wen_q   <= req_wen;
                wdata_q <= req_wdata;
                ctrl_q  <= req_ctrl;
            end
            if (w_commit) begin
                rdata_q <= w_load;
                err_q   <= w_err;
            end
        end
    end

    // Storage is deliberately not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge CLK) begin
        if (!RST && w_commit && w_wen && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wbus[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_responder
// Desc    : Randomised and directed bench for mem_responder against a byte-level model.
// Rev     : 1.0
// ============================================================================
module tb_mem_responder;

    localparam int LAT [3] = '{1, 2, 4};
    localparam int DEP [3] = '{64, 1024, 128};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata[3];
    logic [31:0] rsp_rdata[3];
    logic [2:0]  req_ctrl [3];
    logic [7:0]  mb [3][256];

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wen(req_wen[0]), .req_wdata(req_wdata[0]),
        .req_ctrl(req_ctrl[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );
    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wen(req_wen[1]), .req_wdata(req_wdata[1]),
        .req_ctrl(req_ctrl[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );
    mem_responder #(.DEPTH_WORDS(128), .LATENCY(4)) u_dut2 (
        .CLK(clk), .RST(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_wen(req_wen[2]), .req_wdata(req_wdata[2]),
        .req_ctrl(req_ctrl[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory with RV32 size/sign rules.
    task automatic model(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [2:0] c, output logic [31:0] rd, output logic e);
        int          sz;
        logic [31:0] v;
        sz = (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
        e  = (c == 3'd3) || (c == 3'd6) || (c == 3'd7) || (w && c[2]) ||
             (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0) ||
             (64'(a) >= 64'(4 * DEP[d]));
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < sz; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[d][int'(a) + i];
                if (!c[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                if (!c[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endtask

    task automatic xact(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [2:0] c, input int hold, output logic [31:0] rd, output logic e);
        logic [31:0] erd;
        logic        ee;
        int          lat;
        int          n;
        model(d, a, w, wd, c, erd, ee);
        req_addr[d]  = a;
        req_wen[d]   = w;
        req_wdata[d] = wd;
        req_ctrl[d]  = c;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (hold == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wen[d]   = ~w;
        req_ctrl[d]  = 3'($urandom);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT[d]));
        rd = rsp_rdata[d];
        e  = rsp_err[d];
        chk("rdata", rd, erd);
        chk("err", 32'(e), 32'(ee));
        if (hold > 0) begin
            req_valid[d] = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
                chk("bp_rdata", rsp_rdata[d], erd);
                chk("bp_err", 32'(rsp_err[d]), 32'(ee));
                chk("bp_ready", 32'(req_ready[d]), 32'd0);
            end
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        @(negedge clk);
        chk("idle_ready", 32'(req_ready[d]), 32'd1);
        chk("idle_valid", 32'(rsp_valid[d]), 32'd0);
        chk("idle_rdata", rsp_rdata[d], 32'd0);
        chk("idle_err", 32'(rsp_err[d]), 32'd0);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready[d]), 32'd0);
        chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
        chk("rst_rdata", rsp_rdata[d], 32'd0);
        chk("rst_err", 32'(rsp_err[d]), 32'd0);
        rst[d] = 1'b0;
        @(negedge clk);
        chk("rst_exit_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, a;
        logic        e, w;
        logic [2:0]  c;
        int          acc, bad, prev, seen;

        rst       = 3'b111;
        req_valid = 3'b000;
        req_wen   = 3'b000;
        rsp_ready = 3'b111;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_ctrl[d]  = 3'd0;
            for (int i = 0; i < 256; i++) mb[d][i] = 8'd0;
        end
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            do_reset(d);
            for (int i = 0; i < 64; i++) xact(d, 32'(4 * i), 1'b1, 32'd0, 3'b010, 0, rd, e);
        end

        // Word store/load, sub-word merge and extension
        xact(1, 32'h10, 1'b1, 32'hDEADBEEF, 3'b010, 0, rd, e);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", 32'(e), 32'd0);
        xact(1, 32'h10, 1'b0, 32'd0, 3'b010, 0, rd, e);
        chk("lw_word", rd, 32'hDEADBEEF);
        xact(1, 32'h13, 1'b1, 32'h00000080, 3'b000, 0, rd, e);
        xact(1, 32'h10, 1'b0, 32'd0, 3'b010, 0, rd, e);
        chk("sb_merge", rd, 32'h80ADBEEF);
        xact(1, 32'h13, 1'b0, 32'd0, 3'b000, 0, rd, e);
        chk("lb", rd, 32'hFFFFFF80);
        xact(1, 32'h13, 1'b0, 32'd0, 3'b100, 0, rd, e);
        chk("lbu", rd, 32'h00000080);
        xact(1, 32'h12, 1'b0, 32'd0, 3'b001, 0, rd, e);
        chk("lh", rd, 32'hFFFF80AD);

        // Rejected requests
        xact(1, 32'h11, 1'b0, 32'd0, 3'b010, 0, rd, e);
        chk("err_lw_mis", {rd[30:0], e}, 32'd1);
        xact(1, 32'h13, 1'b1, 32'h0000FFFF, 3'b001, 0, rd, e);
        chk("err_sh_mis", {rd[30:0], e}, 32'd1);
        xact(1, 32'd4096, 1'b0, 32'd0, 3'b010, 0, rd, e);
        chk("err_oob", {rd[30:0], e}, 32'd1);
        xact(1, 32'h10, 1'b0, 32'd0, 3'b011, 0, rd, e);
        chk("err_ctrl", {rd[30:0], e}, 32'd1);
        xact(1, 32'h10, 1'b0, 32'd0, 3'b010, 5, rd, e);
        chk("err_nochange", rd, 32'h80ADBEEF);

        // Reset while BUSY aborts the store
        @(negedge clk);
        req_addr[2]  = 32'h20;
        req_wen[2]   = 1'b1;
        req_wdata[2] = 32'h12345678;
        req_ctrl[2]  = 3'b010;
        req_valid[2] = 1'b1;
        chk("rm_ready", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1 rst[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rm_rst_ready", 32'(req_ready[2]), 32'd0);
        chk("rm_rst_valid", 32'(rsp_valid[2]), 32'd0);
        rst[2] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1;
        end
        chk("rm_no_rsp", 32'(seen), 32'd0);
        chk("rm_ready_after", 32'(req_ready[2]), 32'd1);
        xact(2, 32'h20, 1'b0, 32'd0, 3'b010, 0, rd, e);
        chk("rm_lw", rd, 32'd0);

        // LATENCY=1 back-to-back with rsp_ready tied high
        rsp_ready[0] = 1'b1;
        req_addr[0]  = 32'h0;
        req_wen[0]   = 1'b0;
        req_ctrl[0]  = 3'b010;
        req_valid[0] = 1'b1;
        acc = 0; bad = 0; prev = 0;
        for (int k = 0; k < 20; k++) begin
            if (prev != 0 && !rsp_valid[0]) bad++;
            prev = (req_valid[0] && req_ready[0]) ? 1 : 0;
            acc += prev;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        chk("thr_accepts", 32'(acc), 32'd10);
        chk("thr_rsp_next", 32'(bad), 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Randomised traffic on every latency
        for (int d = 0; d < 3; d++) begin
            repeat (40) begin
                if ($urandom_range(0, 9) == 0) a = 32'(4 * DEP[d]) + 32'(4 * $urandom_range(0, 3));
                else a = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                c = 3'($urandom_range(0, 7));
                w = 1'($urandom_range(0, 1));
                xact(d, a, w, $urandom, c, $urandom_range(0, 2), rd, e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
